layer_data_loader: RTL
======================

# layer_data_loader

Host-side feeder for the float16 layer-parallel convolution engine. Accepts a serial float16 word stream with a valid/ready handshake and packs it into weight blocks and feature-map blocks. Drives the engine's layer-init write interface and done flags, waits for both RAM-ready flags, then switches the engine to conv. While conv runs, it services the engine's weight-RAM update requests from the same stream.

## Interface
- DATA_WIDTH, 16, float16 word width
- PARA_X, 3, MAC groups (feature-map block rows)
- PARA_Y, 3, MACs per group (feature-map block columns)
- PARA_KERNEL, 2, kernels written in parallel
- KERNEL_SIZE_MAX, 5, maximum kernel edge
- FM_SIZE_WIDTH, 10, feature-map size field width
- KERNEL_SIZE_WIDTH, 6, kernel size field width
- WRITE_ADDR_WIDTH, 3, feature-map block address width
- WEIGHT_WRITE_ADDR_WIDTH, 5, weight block address width
---
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_fm_size  in  FM_SIZE_WIDTH  feature-map size for conv
- cfg_kernel_size  in  KERNEL_SIZE_WIDTH  kernel edge K
- cfg_fm_blocks  in  WRITE_ADDR_WIDTH+1  number of feature-map blocks NF
- cfg_weight_blocks  in  WEIGHT_WRITE_ADDR_WIDTH+1  number of weight blocks NW
- cfg_err  out  1  one-cycle pulse when a start is rejected
- s_data  in  DATA_WIDTH  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts a word
- layer_type  out  2  0 = init, 1 = conv
- fm_size  out  FM_SIZE_WIDTH  feature-map size to the engine
- kernel_size  out  KERNEL_SIZE_WIDTH  kernel size to the engine
- init_fm_data  out  PARA_X*PARA_Y*DATA_WIDTH  feature-map block
- write_fm_data_addr  out  WRITE_ADDR_WIDTH  feature-map block address
- init_fm_data_done  out  1  all feature-map blocks sent
- weight_data  out  KERNEL_SIZE_MAX^2*PARA_KERNEL*DATA_WIDTH  weight block
- write_weight_data_addr  out  WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL  weight address, replicated per kernel
- weight_data_done  out  1  weight block(s) valid
- update_weight_ram  in  1  engine requests a weight reload
- update_weight_ram_addr  in  1  reload target address
- init_fm_ram_ready  in  1  engine feature-map RAM initialised
- init_weight_ram_ready  in  1  engine weight RAM initialised
- layer_ready  in  1  engine finished the layer
- busy  out  1  high whenever the FSM is not IDLE
- done  out  1  one-cycle pulse when the layer completes

## Operation
- States: IDLE, LOAD_W, LOAD_FM, WAIT_RDY, RUN, RELOAD.
- IDLE, on cfg_start:
  - Latches the config.
  - Rejects the start, pulses cfg_err and stays in IDLE if K==0, K>KERNEL_SIZE_MAX, NF==0 or NW==0.
  - Otherwise clears both done flags and goes to LOAD_W.
- s_ready=1 only in LOAD_W, LOAD_FM and RELOAD (while a reload is pending). A word is accepted when s_valid && s_ready. Stalls hold all counters.
- Weight block: PARA_KERNEL*K*K words.
  - Kernel k takes words k*K*K..(k+1)*K*K-1.
  - Within a kernel, word i goes to bits [k*KMAX²*DW + i*DW +: DW].
  - Unused words are zero.
- Feature-map block: PARA_X*PARA_Y words. Word j goes to bits [j*DW +: DW].
- Words are assembled in a staging register. On the final word of a block, the next edge copies the staging register to the output bus and sets the address to the block index. Outputs hold until the next block completes, so repeated engine sampling is idempotent.
- LOAD_W: after block NW-1 is presented, the next edge sets weight_data_done=1 and moves to LOAD_FM.
- LOAD_FM: after block NF-1 is presented, the next edge sets init_fm_data_done=1 and moves to WAIT_RDY. Feature-map data and address are held.
- WAIT_RDY: on init_fm_ram_ready && init_weight_ram_ready, the next edge sets layer_type=1, fm_size=cfg_fm_size, kernel_size=cfg_kernel_size, and moves to RUN.
- RUN:
  - layer_ready: pulse done, set layer_type=0, clear both done flags, go to IDLE.
  - update_weight_ram (without layer_ready): latch the address, weight_data_done=0, go to RELOAD.
  - layer_ready has priority when both occur in the same cycle.
- RELOAD:
  - Accepts one weight block.
  - Presents it with write_weight_data_addr = latched address replicated PARA_KERNEL times.
  - The next edge sets weight_data_done=1 and returns to RUN.
- update_weight_ram outside RUN is ignored. cfg_start outside IDLE is ignored.
- Block counters are WRITE_ADDR_WIDTH+1 / WEIGHT_WRITE_ADDR_WIDTH+1 bits wide, so there is no wrap at NF=2^WRITE_ADDR_WIDTH.

## Timing
- Reset values: every output is 0, including the staging register, the counters and s_ready; the FSM is in IDLE.
- Reset mid-operation returns to these values immediately; partial blocks are discarded.
- Block latency: output bus valid 1 cycle after the final word handshake.
- Done-flag latency: weight_data_done / init_fm_data_done rise 1 cycle after the last block is presented.
- Ready-to-conv latency: layer_type=1 appears 1 cycle after both ready flags are high.
- Back-to-back blocks at full rate: one block per PARA_KERNEL*K*K (weights) or PARA_X*PARA_Y (feature map) valid cycles. There is no bubble between blocks.
- s_ready drops in the cycle after the last word of the last block of a phase is accepted; words beyond that point are not consumed.

## Test plan
- K=3, NW=2, NF=4, fm_size=6, continuous valid:
  - Weight block 0: kernel 0 = 3c00,4000,0000,3c00,4000,3c00,4200,4000,3c00 (LSB first), kernel 1 identical except last word 4000.
  - Expected: addr 0 then 1, weight_data_done=1, feature-map addresses 0..3, init_fm_data_done=1.
  - With both ready flags high: layer_type=1, fm_size=6, kernel_size=3 one cycle later.
- Random s_valid gaps during both load phases -> the same output sequence and values as the continuous case; no word is dropped or duplicated.
- In RUN, pulse update_weight_ram with addr=1 and stream 18 words -> weight_data_done drops, then the block appears at address 1 in both kernel fields, then weight_data_done=1 one cycle later.
- layer_ready and update_weight_ram in the same cycle -> done pulses, layer_type=0, IDLE, no reload.
- cfg_start with K=6, then with NF=0 -> cfg_err pulses each time, busy stays 0.
- Assert rst mid-LOAD_FM after 5 words -> all outputs 0; a fresh start reloads cleanly from address 0.

Source files
------------

// File: rtl/layer_data_loader.sv
// Host-side feeder for the float16 layer-parallel convolution engine: packs a serial
// word stream into weight and feature-map blocks, sequences init -> conv, and serves weight reloads.
module layer_data_loader #(
  parameter int DATA_WIDTH              = 16,
  parameter int PARA_X                  = 3,
  parameter int PARA_Y                  = 3,
  parameter int PARA_KERNEL             = 2,
  parameter int KERNEL_SIZE_MAX         = 5,
  parameter int FM_SIZE_WIDTH           = 10,
  parameter int KERNEL_SIZE_WIDTH       = 6,
  parameter int WRITE_ADDR_WIDTH        = 3,
  parameter int WEIGHT_WRITE_ADDR_WIDTH = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_start,
  input  logic [FM_SIZE_WIDTH-1:0]               cfg_fm_size,
  input  logic [KERNEL_SIZE_WIDTH-1:0]           cfg_kernel_size,
  input  logic [WRITE_ADDR_WIDTH:0]              cfg_fm_blocks,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH:0]       cfg_weight_blocks,
  output logic                                   cfg_err,
  input  logic [DATA_WIDTH-1:0]                  s_data,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  output logic [1:0]                             layer_type,
  output logic [FM_SIZE_WIDTH-1:0]               fm_size,
  output logic [KERNEL_SIZE_WIDTH-1:0]           kernel_size,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]    init_fm_data,
  output logic [WRITE_ADDR_WIDTH-1:0]            write_fm_data_addr,
  output logic                                   init_fm_data_done,
  output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
  output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] write_weight_data_addr,
  output logic                                   weight_data_done,
  input  logic                                   update_weight_ram,
  input  logic                                   update_weight_ram_addr,
  input  logic                                   init_fm_ram_ready,
  input  logic                                   init_weight_ram_ready,
  input  logic                                   layer_ready,
  output logic                                   busy,
  output logic                                   done
);

  localparam int KK_MAX  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int W_WORDS = PARA_KERNEL * KK_MAX;
  localparam int F_WORDS = PARA_X * PARA_Y;
  localparam int KK_W    = (KK_MAX > 1) ? $clog2(KK_MAX) : 1;
  localparam int KERN_W  = (PARA_KERNEL > 1) ? $clog2(PARA_KERNEL) : 1;
  localparam int W_IDX_W = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;
  localparam int F_IDX_W = (F_WORDS > 1) ? $clog2(F_WORDS) : 1;
  localparam int WA      = WEIGHT_WRITE_ADDR_WIDTH;
  localparam int FA      = WRITE_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_FM, WAIT_RDY, RUN, RELOAD} state_t;

  state_t state, state_next;

  logic [FM_SIZE_WIDTH-1:0]     fm_size_q;
  logic [KERNEL_SIZE_WIDTH-1:0] k_q;
  logic [FA:0]                  nf_q, f_blk;
  logic [WA:0]                  nw_q, w_blk;
  logic [KK_W-1:0]              kk_last, in_idx;
  logic [KERN_W-1:0]            kern;
  logic [F_IDX_W-1:0]           f_word;
  logic                         phase_end;   // last block of a phase presented, flag rises next edge
  logic                         reload_addr;

  logic [W_WORDS-1:0][DATA_WIDTH-1:0] w_stage, w_merged;
  logic [F_WORDS-1:0][DATA_WIDTH-1:0] f_stage, f_merged;
  logic [W_IDX_W-1:0]                 w_slot;

  logic accept, w_phase, w_last, f_last, blk_final, last_blk, cfg_bad, rams_ready;

  assign busy       = (state != IDLE);
  assign s_ready    = (state == LOAD_W || state == LOAD_FM || state == RELOAD) && !phase_end;
  assign accept     = s_valid && s_ready;
  assign w_phase    = (state == LOAD_W || state == RELOAD);
  assign w_last     = (in_idx == kk_last) && (kern == KERN_W'(PARA_KERNEL - 1));
  assign f_last     = (f_word == F_IDX_W'(F_WORDS - 1));
  assign blk_final  = accept && (w_phase ? w_last : f_last);
  assign w_slot     = W_IDX_W'(kern * KK_MAX) + W_IDX_W'(in_idx);
  assign rams_ready = init_fm_ram_ready && init_weight_ram_ready;
  assign cfg_bad    = (cfg_kernel_size == '0) ||
                      (cfg_kernel_size > KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX)) ||
                      (cfg_fm_blocks == '0) || (cfg_weight_blocks == '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    last_blk = 1'b0;
    case (state)
      LOAD_W:  last_blk = ((w_blk + (WA+1)'(1)) == nw_q);
      LOAD_FM: last_blk = ((f_blk + (FA+1)'(1)) == nf_q);
      RELOAD:  last_blk = 1'b1;
      default: last_blk = 1'b0;
    endcase
  end

  // Staging contents including the word being accepted this cycle.
  always_comb begin
    w_merged = w_stage;
    f_merged = f_stage;
    if (accept && w_phase)  w_merged[w_slot] = s_data;
    if (accept && !w_phase) f_merged[f_word] = s_data;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (cfg_start && !cfg_bad) state_next = LOAD_W;
      LOAD_W:   if (phase_end) state_next = LOAD_FM;
      LOAD_FM:  if (phase_end) state_next = WAIT_RDY;
      WAIT_RDY: if (rams_ready) state_next = RUN;
      RUN:      if (layer_ready) state_next = IDLE;
                else if (update_weight_ram) state_next = RELOAD;
      RELOAD:   if (phase_end) state_next = RUN;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: staging and output buses are plain flops, reset so a partial block never leaks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fm_size_q              <= '0;
      k_q                    <= '0;
      nf_q                   <= '0;
      nw_q                   <= '0;
      kk_last                <= '0;
      f_blk                  <= '0;
      w_blk                  <= '0;
      in_idx                 <= '0;
      kern                   <= '0;
      f_word                 <= '0;
      phase_end              <= 1'b0;
      reload_addr            <= 1'b0;
      w_stage                <= '0;
      f_stage                <= '0;
      cfg_err                <= 1'b0;
      done                   <= 1'b0;
      layer_type             <= '0;
      fm_size                <= '0;
      kernel_size            <= '0;
      init_fm_data           <= '0;
      write_fm_data_addr     <= '0;
      init_fm_data_done      <= 1'b0;
      weight_data            <= '0;
      write_weight_data_addr <= '0;
      weight_data_done       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      cfg_err <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: if (cfg_start) begin
          fm_size_q <= cfg_fm_size;
          k_q       <= cfg_kernel_size;
          nf_q      <= cfg_fm_blocks;
          nw_q      <= cfg_weight_blocks;
          kk_last   <= KK_W'(cfg_kernel_size * cfg_kernel_size - 1);
          if (cfg_bad) begin
            cfg_err <= 1'b1;
          end else begin
            weight_data_done  <= 1'b0;
            init_fm_data_done <= 1'b0;
            f_blk     <= '0;
            w_blk     <= '0;
            in_idx    <= '0;
            kern      <= '0;
            f_word    <= '0;
            phase_end <= 1'b0;
            w_stage   <= '0;
            f_stage   <= '0;
          end
        end
        LOAD_W, LOAD_FM, RELOAD: begin
          if (phase_end) begin
            phase_end <= 1'b0;
            if (state == LOAD_FM) init_fm_data_done <= 1'b1;
            else                  weight_data_done  <= 1'b1;
          end else if (accept) begin
            if (w_phase) begin
              if (w_last) begin
                weight_data <= w_merged;
                w_stage     <= '0;
                in_idx      <= '0;
                kern        <= '0;
                w_blk       <= w_blk + (WA+1)'(1);
                if (state == RELOAD)
                  write_weight_data_addr <= {PARA_KERNEL{WA'(reload_addr)}};
                else
                  write_weight_data_addr <= {PARA_KERNEL{w_blk[WA-1:0]}};
              end else begin
                w_stage <= w_merged;
                if (in_idx == kk_last) begin
                  in_idx <= '0;
                  kern   <= kern + KERN_W'(1);
                end else begin
                  in_idx <= in_idx + KK_W'(1);
                end
              end
            end else begin
              if (f_last) begin
                init_fm_data       <= f_merged;
                write_fm_data_addr <= f_blk[FA-1:0];
                f_stage            <= '0;
                f_word             <= '0;
                f_blk              <= f_blk + (FA+1)'(1);
              end else begin
                f_stage <= f_merged;
                f_word  <= f_word + F_IDX_W'(1);
              end
            end
            if (blk_final && last_blk) phase_end <= 1'b1;
          end
        end
        WAIT_RDY: if (rams_ready) begin
          layer_type  <= 2'd1;
          fm_size     <= fm_size_q;
          kernel_size <= k_q;
        end
        RUN: begin
          if (layer_ready) begin
            done              <= 1'b1;
            layer_type        <= 2'd0;
            weight_data_done  <= 1'b0;
            init_fm_data_done <= 1'b0;
          end else if (update_weight_ram) begin
            reload_addr      <= update_weight_ram_addr;
            weight_data_done <= 1'b0;
            in_idx           <= '0;
            kern             <= '0;
            w_stage          <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
